// File: rtl/aes_pkg.sv
// Shared types, constants and round helpers for the iterative AES-128 encryptor.
// Byte k of a block is state[k/4][k%4]; column 0 occupies the most significant 32 bits.
package aes_pkg;

    localparam logic [3:0] NR = 4'd10;

    typedef logic [7:0]            byte_t;
    typedef logic [0:3][7:0]       word_t;
    typedef logic [0:3][0:3][7:0]  state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_state_e;

    localparam byte_t RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic byte_t rcon_for(input logic [3:0] rnd);
        byte_t r;
        r = 8'h00;
        if (rnd >= 4'd1 && rnd <= NR) begin
            r = RCON[rnd];
        end
        return r;
    endfunction

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column times the fixed polynomial {03}x^3 + {01}x^2 + {01}x + {02}.
    function automatic word_t mix_column(input word_t a);
        word_t m;
        m[0] = xtime(a[0]) ^ xtime(a[1]) ^ a[1] ^ a[2] ^ a[3];
        m[1] = a[0] ^ xtime(a[1]) ^ xtime(a[2]) ^ a[2] ^ a[3];
        m[2] = a[0] ^ a[1] ^ xtime(a[2]) ^ xtime(a[3]) ^ a[3];
        m[3] = xtime(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xtime(a[3]);
        return m;
    endfunction

    // Row r rotates left by r columns.
    function automatic state_t shift_rows(input state_t s);
        state_t o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[c][r] = s[2'(c + r)][r];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box; the inverse of the decryption path's inverse S-box.
module aes_sbox
    import aes_pkg::*;
(
    input  byte_t in_i,
    output byte_t out_o
);

    // Entry 0 sits in the top byte, so entry n starts at bit 8*(255-n) = {~n, 3'b000}.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_o = SBOX_TABLE[{~in_i, 3'b000} +: 8];

endmodule

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128 encryptor: one round per clock with the round key expanded alongside.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
module aes_encrypt_core
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] plaintext,
    input  logic [0:127] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] ciphertext,
    output logic         busy
);

    fsm_state_e state_q, state_d;
    logic [3:0] round_q, round_d;
    state_t     data_q, data_d;
    state_t     rk_q, rk_d;

    state_t     sub_bytes;
    word_t      sub_word;
    state_t     next_rk;
    state_t     shifted;
    state_t     mixed;
    state_t     round_out;
    byte_t      rcon_b;

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            aes_sbox u_sbox (
                .in_i  (data_q[c][r]),
                .out_o (sub_bytes[c][r])
            );
        end
        // SubWord(RotWord(w3)): output byte c comes from w3 byte c+1.
        aes_sbox u_kbox (
            .in_i  (rk_q[3][(c + 1) % 4]),
            .out_o (sub_word[c])
        );
    end

    assign rcon_b = rcon_for(round_q);

    always_comb begin
        next_rk    = rk_q;
        next_rk[0] = rk_q[0] ^ sub_word ^ {rcon_b, 24'h000000};
        next_rk[1] = rk_q[1] ^ next_rk[0];
        next_rk[2] = rk_q[2] ^ next_rk[1];
        next_rk[3] = rk_q[3] ^ next_rk[2];
    end

    always_comb begin
        shifted = shift_rows(sub_bytes);
        mixed   = shifted;
        for (int c = 0; c < 4; c++) begin
            if (round_q != NR) begin
                mixed[c] = mix_column(shifted[c]);
            end
        end
        round_out = mixed ^ next_rk;
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        data_d  = data_q;
        rk_d    = rk_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = state_t'(plaintext ^ key);
                    rk_d    = state_t'(key);
                    round_d = 4'd1;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (round_q == 4'd0 || round_q > NR) begin
                    round_d = 4'd0;
                    state_d = IDLE;
                end else begin
                    data_d  = round_out;
                    rk_d    = next_rk;
                    round_d = round_q + 4'd1;
                    if (round_q == NR) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    round_d = 4'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                round_d = 4'd0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            round_q <= 4'd0;
            data_q  <= '0;
            rk_q    <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            data_q  <= data_d;
            rk_q    <= rk_d;
        end
    end

    // All outputs decode registers only; none depends on in_valid or out_ready.
    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q == ROUND) || (state_q == DONE);
    assign ciphertext = data_q;

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Self-checking bench for aes_encrypt_core: known-answer table, timing and corner sequences.
module tb_aes_encrypt_core;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] plaintext;
    logic [0:127] key;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] ciphertext;
    logic         busy;

    aes_encrypt_core dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- bookkeeping ----------------
    int tests_run    = 0;
    int tests_failed = 0;

    logic [127:0] exp_q[$];
    logic [127:0] cur_exp = '0;
    int  accept_cnt       = 0;
    int  out_cnt          = 0;
    int  accept_edge      = 0;
    int  last_accept_edge = 0;
    bit  check_gap        = 1'b0;
    bit  ov_prev          = 1'b0;

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;
    vec_t vecs[3];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    // Sampled on the falling edge: a transfer seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                if (check_gap) begin
                    check_int("accept_gap", cyc + 1 - last_accept_edge, 12);
                end
                accept_cnt++;
                accept_edge      = cyc + 1;
                last_accept_edge = cyc + 1;
                exp_q.push_back(cur_exp);
            end
            if (out_valid && !ov_prev) begin
                check_int("latency", cyc - accept_edge, 10);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", ciphertext, '0);
                    tests_failed += (ciphertext === '0) ? 1 : 0;
                    if (ciphertext === '0) $display("FAIL unexpected_output: out_valid with empty queue");
                end else begin
                    check("ciphertext", ciphertext, exp_q.pop_front());
                end
                out_cnt++;
            end
        end
        ov_prev = out_valid;
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the edge that accepted the block.
    task automatic send_block(input logic [127:0] k, input logic [127:0] p,
                              input logic [127:0] e, input bit drop_after);
        int start  = accept_cnt;
        int waited = 0;
        key       = k;
        plaintext = p;
        cur_exp   = e;
        in_valid  = 1'b1;
        while (accept_cnt == start && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (accept_cnt == start) begin
            check_int("accept_timeout", 0, 1);
            in_valid = 1'b0;
        end else if (drop_after) begin
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_outputs(input int target);
        int waited = 0;
        while (out_cnt < target && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        check_int("outputs_seen", out_cnt, target);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int tgt;
        int acc0;
        logic [127:0] held;

        vecs[0] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    pt:  128'h3243f6a8885a308d313198a2e0370734,
                    ct:  128'h3925841d02dc09fbdc118597196a0b32};
        vecs[1] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                    pt:  128'h00112233445566778899aabbccddeeff,
                    ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[2] = '{key: 128'h0,
                    pt:  128'h0,
                    ct:  128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        key       = '0;
        plaintext = '0;

        #3;
        check_int("reset_in_ready", int'(in_ready), 1);
        check_int("reset_out_valid", int'(out_valid), 0);
        check_int("reset_busy", int'(busy), 0);
        check("reset_ciphertext", ciphertext, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Known-answer table.
        for (int i = 0; i < 3; i++) begin
            tgt = out_cnt + 1;
            send_block(vecs[i].key, vecs[i].pt, vecs[i].ct, 1'b1);
            check_int("busy_after_accept", int'(busy), 1);
            check_int("in_ready_after_accept", int'(in_ready), 0);
            wait_outputs(tgt);
            check_int("idle_after_output", int'(in_ready), 1);
        end

        // Back-pressure: DONE must hold for 20 cycles with stable data.
        out_ready = 1'b0;
        tgt = out_cnt + 1;
        send_block(vecs[0].key, vecs[0].pt, vecs[0].ct, 1'b1);
        for (int w = 0; w < 30 && !out_valid; w++) begin
            @(posedge clk); #1;
        end
        check_int("bp_out_valid_seen", int'(out_valid), 1);
        held = ciphertext;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            check_int("bp_out_valid_held", int'(out_valid), 1);
            check("bp_ciphertext_held", ciphertext, vecs[0].ct);
            check("bp_ciphertext_stable", ciphertext, held);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_outputs(tgt);

        // Input churn during ROUND: no second accept, result unaffected.
        tgt  = out_cnt + 1;
        acc0 = accept_cnt;
        send_block(vecs[1].key, vecs[1].pt, vecs[1].ct, 1'b0);
        cur_exp = '0;
        for (int w = 0; w < 7; w++) begin
            key       = {$urandom, $urandom, $urandom, $urandom};
            plaintext = {$urandom, $urandom, $urandom, $urandom};
            in_valid  = 1'($urandom_range(0, 1)) | (w == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_outputs(tgt);
        check_int("churn_accepts", accept_cnt, acc0 + 1);

        // Asynchronous reset during round 5.
        send_block(vecs[1].key, vecs[1].pt, vecs[1].ct, 1'b1);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_int("midrst_in_ready", int'(in_ready), 1);
        check_int("midrst_out_valid", int'(out_valid), 0);
        check_int("midrst_busy", int'(busy), 0);
        check("midrst_ciphertext", ciphertext, '0);
        exp_q.delete();
        tgt = out_cnt;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check_int("midrst_no_output", out_cnt, tgt);
        check_int("midrst_idle", int'(in_ready), 1);
        tgt = out_cnt + 1;
        send_block(vecs[0].key, vecs[0].pt, vecs[0].ct, 1'b1);
        wait_outputs(tgt);

        // Back-to-back with in_valid and out_ready held high.
        tgt = out_cnt + 3;
        send_block(vecs[0].key, vecs[0].pt, vecs[0].ct, 1'b0);
        check_gap = 1'b1;
        send_block(vecs[1].key, vecs[1].pt, vecs[1].ct, 1'b0);
        send_block(vecs[2].key, vecs[2].pt, vecs[2].ct, 1'b1);
        check_gap = 1'b0;
        wait_outputs(tgt);

        repeat (3) @(posedge clk);
        check_int("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
